// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU datapath defaults and operation encoding
package alu_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG = 16;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
endpackage

// File: rtl/fa.sv
// fa: single-bit full adder
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/rca_seg.sv
// rca_seg: SEG-bit ripple-carry segment exposing carry-out and carry into its MSB
module rca_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);
  logic [SEG:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign co = c[SEG];
  assign cm = c[SEG-1];
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented pipelined add/sub with carry, overflow and zero flags behind valid/ready
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG = DEF_SEG
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int STAGES = WIDTH / SEG;
  logic adv;
  logic vld [STAGES];
  logic cy [STAGES];
  logic [WIDTH-1:0] av [STAGES];
  logic [WIDTH-1:0] bv [STAGES];
  logic [WIDTH-1:0] sv [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [SEG-1:0] ss [STAGES];
  logic sc [STAGES];
  logic sm [STAGES];
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_seg #(.SEG(SEG)) u_seg (
      .a(av[k][k*SEG +: SEG]),
      .b(bv[k][k*SEG +: SEG]),
      .ci(cy[k]),
      .s(ss[k]),
      .co(sc[k]),
      .cm(sm[k])
    );
  end
  // operands ride along full width; finished segments are merged into the partial sum
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ns[k] = sv[k];
      ns[k][k*SEG +: SEG] = ss[k];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) vld[k] <= 1'b0;
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (adv) begin
      vld[0] <= in_valid;
      av[0] <= a;
      bv[0] <= (op_e'(sub) == OP_SUB) ? ~b : b;
      cy[0] <= (op_e'(sub) == OP_SUB) ? 1'b1 : cin;
      sv[0] <= '0;
      for (int k = 1; k < STAGES; k++) begin
        vld[k] <= vld[k-1];
        av[k] <= av[k-1];
        bv[k] <= bv[k-1];
        cy[k] <= sc[k-1];
        sv[k] <= ns[k-1];
      end
      out_valid <= vld[STAGES-1];
      sum <= ns[STAGES-1];
      cout <= sc[STAGES-1];
      overflow <= sm[STAGES-1] ^ sc[STAGES-1];
      zero <= ~|ns[STAGES-1];
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe plus STAGES=1 and STAGES=4 sweeps
module tb_addsub_pipe;
  typedef struct packed {logic [31:0] s; logic co; logic ov; logic z;} exp_t;
  logic clock = 0;
  logic reset = 1;
  logic in_valid = 0, in_ready, sub = 0, cin = 0, out_valid, out_ready = 1;
  logic [31:0] a = 0, b = 0, sum;
  logic cout, overflow, zero;
  logic v1 = 0, r1, ov1, rd1 = 1, co1, of1, z1;
  logic [15:0] a1 = 0, b1 = 0, s1;
  logic v4 = 0, r4, ov4, rd4 = 1, co4, of4, z4;
  logic [63:0] a4 = 0, b4 = 0, s4;
  int errors = 0, checks = 0, n_out = 0, cyc = 0;
  exp_t q[$];
  int hs_cyc[$];

  addsub_pipe #(.WIDTH(32), .SEG(16)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .overflow(overflow), .zero(zero));
  addsub_pipe #(.WIDTH(16), .SEG(16)) dut1 (
    .clock(clock), .reset(reset), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
    .sub(1'b0), .cin(1'b0), .out_valid(ov1), .out_ready(rd1), .sum(s1),
    .cout(co1), .overflow(of1), .zero(z1));
  addsub_pipe #(.WIDTH(64), .SEG(16)) dut4 (
    .clock(clock), .reset(reset), .in_valid(v4), .in_ready(r4), .a(a4), .b(b4),
    .sub(1'b0), .cin(1'b0), .out_valid(ov4), .out_ready(rd4), .sum(s4),
    .cout(co4), .overflow(of4), .zero(z4));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    logic [31:0] yy;
    logic [32:0] f;
    yy = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yy} + {32'b0, s ? 1'b1 : c};
    model.s = f[31:0];
    model.co = f[32];
    model.ov = (x[31] == yy[31]) && (f[31] != x[31]);
    model.z = (f[31:0] == 32'd0);
  endfunction

  // scoreboard: every output handshake retires the oldest expected result
  always @(negedge clock) begin
    #2;
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      checks++;
      n_out++;
      hs_cyc.push_back(cyc);
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got sum=%h with no pending op", sum);
      end else begin
        e = q.pop_front();
        if ({sum, cout, overflow, zero} !== e)
          $display("FAIL result: got sum=%h c=%b v=%b z=%b, want sum=%h c=%b v=%b z=%b",
                   sum, cout, overflow, zero, e.s, e.co, e.ov, e.z);
        if ({sum, cout, overflow, zero} !== e) errors++;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    int n = 0;
    in_valid = 1; a = x; b = y; sub = s; cin = c;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clock); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
    end else q.push_back(model(x, y, s, c));
    @(negedge clock);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clock); n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", q.size());
      q.delete();
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    #1;
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if ({sum, cout, overflow, zero} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs: got sum=%h c=%b v=%b z=%b want all 0", sum, cout, overflow, zero);
    end
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clock);
  endtask

  task automatic test_carry();
    int acc;
    out_ready = 1;
    send(32'h0000FFFF, 32'h1, 0, 0);
    acc = cyc;
    #3;
    while (!out_valid && cyc - acc < 20) begin @(negedge clock); #3; end
    checks++;
    if (cyc - acc != 2) begin errors++; $display("FAIL carry_latency: got %0d want 2", cyc - acc); end
    checks++;
    if ({sum, cout, overflow, zero} !== {32'h00010000, 3'b000}) begin
      errors++; $display("FAIL carry_value: got sum=%h c=%b v=%b z=%b want 00010000 0 0 0", sum, cout, overflow, zero);
    end
    @(negedge clock);
    drain();
  endtask

  task automatic test_flags();
    out_ready = 1;
    send(32'h7FFFFFFF, 32'h1, 0, 0);
    send(32'h5, 32'h5, 1, 0);
    send(32'h0, 32'h1, 1, 0);
    send(32'h80000000, 32'h1, 1, 1);
    send(32'hFFFFFFFF, 32'h1, 0, 0);
    send(32'h1234ABCD, 32'hEDCB5432, 0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    int c0;
    out_ready = 1;
    hs_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
    drain();
    checks++;
    if (hs_cyc.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", hs_cyc.size()); end
    else begin
      checks++;
      if (hs_cyc[7] - hs_cyc[0] != 7) begin errors++; $display("FAIL b2b_rate: span %0d want 7", hs_cyc[7] - hs_cyc[0]); end
      checks++;
      if (hs_cyc[0] - (c0 + 1) != 2) begin errors++; $display("FAIL b2b_latency: got %0d want 2", hs_cyc[0] - (c0 + 1)); end
    end
  endtask

  task automatic test_stall();
    int base = n_out;
    logic [34:0] held;
    out_ready = 1;
    fork
      for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom));
      begin
        repeat (3) @(negedge clock);
        out_ready = 0;
        #1;
        checks++;
        if (in_ready !== 0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
        held = {sum, cout, overflow, zero};
        repeat (2) begin
          @(negedge clock); #1;
          checks++;
          if ({out_valid, sum, cout, overflow, zero} !== {1'b1, held}) begin
            errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", out_valid, {sum, cout, overflow, zero}, held);
          end
        end
        @(negedge clock);
        out_ready = 1;
      end
    join
    drain();
    checks++;
    if (n_out - base != 6) begin errors++; $display("FAIL stall_count: got %0d want 6", n_out - base); end
  endtask

  task automatic test_reset_mid();
    int base;
    out_ready = 1;
    send($urandom, $urandom, 0, 1);
    send($urandom, $urandom, 1, 0);
    reset = 1;
    q.delete();
    @(negedge clock);
    #1;
    checks++;
    if ({out_valid, sum, cout, overflow, zero} !== 36'd0) begin
      errors++; $display("FAIL midreset_outputs: got v=%b sum=%h c=%b v=%b z=%b want all 0", out_valid, sum, cout, overflow, zero);
    end
    reset = 0;
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL midreset_ghost: out_valid=%b want 0", out_valid); end
    @(negedge clock);
    base = n_out;
    send(32'd100, 32'd23, 0, 0);
    drain();
    repeat (3) @(negedge clock);
    checks++;
    if (n_out - base != 1) begin errors++; $display("FAIL midreset_fresh: got %0d results want 1", n_out - base); end
  endtask

  task automatic test_stages1();
    int acc;
    v1 = 1; a1 = 16'hFFFF; b1 = 16'h0001;
    #1;
    checks++;
    if (r1 !== 1) begin errors++; $display("FAIL s1_ready: got %b want 1", r1); end
    @(negedge clock);
    v1 = 0;
    acc = cyc;
    #1;
    while (!ov1 && cyc - acc < 20) begin @(negedge clock); #1; end
    checks++;
    if (cyc - acc != 1) begin errors++; $display("FAIL s1_latency: got %0d want 1", cyc - acc); end
    checks++;
    if ({s1, co1, of1, z1} !== {16'h0000, 3'b101}) begin
      errors++; $display("FAIL s1_wrap: got sum=%h c=%b v=%b z=%b want 0000 1 0 1", s1, co1, of1, z1);
    end
    @(negedge clock);
  endtask

  task automatic test_stages4();
    int acc;
    v4 = 1; a4 = 64'hFFFFFFFFFFFFFFFF; b4 = 64'h1;
    #1;
    checks++;
    if (r4 !== 1) begin errors++; $display("FAIL s4_ready: got %b want 1", r4); end
    @(negedge clock);
    v4 = 0;
    acc = cyc;
    #1;
    while (!ov4 && cyc - acc < 20) begin @(negedge clock); #1; end
    checks++;
    if (cyc - acc != 4) begin errors++; $display("FAIL s4_latency: got %0d want 4", cyc - acc); end
    checks++;
    if ({s4, co4, of4, z4} !== {64'h0, 3'b101}) begin
      errors++; $display("FAIL s4_wrap: got sum=%h c=%b v=%b z=%b want 0 1 0 1", s4, co4, of4, z4);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clock);
    test_reset();
    test_carry();
    test_flags();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_stages1();
    test_stages4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
